// File: rtl/proc_pkg.sv
// Shared processor constants: bus width, halt word, feeder states
// and the opcode field layout used by the controller.
package proc_pkg;
    localparam int WIDTH = 10;
    localparam logic [WIDTH-1:0] HALT_WORD = 10'h3FF;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_RUN  = 2'd1,
        FS_HALT = 2'd2
    } feeder_state_t;

    localparam int OPC_HI = 9;
    localparam int OPC_LO = 6;
    localparam logic [3:0] OP_LOAD = 4'h0;
    localparam logic [3:0] OP_MOVI = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;

    function automatic logic [3:0] opcode_of(input logic [WIDTH-1:0] w);
        return w[OPC_HI:OPC_LO];
    endfunction
endpackage

// File: rtl/program_feeder_store.sv
// Program word array: synchronous write, asynchronous read.
// Addresses at or beyond DEPTH are dropped rather than wrapped.
module program_store #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we && (int'(i_waddr) < DEPTH)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = (int'(i_raddr) < DEPTH) ? r_mem[i_raddr] : '0;
endmodule

// File: rtl/program_feeder.sv
// Feeds preloaded program words onto the shared data bus on Ext
// requests and counts completed instructions.
module program_feeder #(
    parameter int WIDTH = proc_pkg::WIDTH,
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter logic [WIDTH-1:0] HALT_WORD = WIDTH'(proc_pkg::HALT_WORD)
) (
    input  logic             CLKb,
    input  logic             RESETn,
    input  logic             LOAD_EN,
    input  logic [AW-1:0]    LOAD_ADDR,
    input  logic [WIDTH-1:0] LOAD_DATA,
    input  logic             RUN,
    input  logic             EXT,
    input  logic             DONE,
    output logic [WIDTH-1:0] BUS_OUT,
    output logic             BUS_DRIVE,
    output logic [AW-1:0]    PC,
    output logic [7:0]       INSTR_CNT,
    output logic             BUSY,
    output logic             HALTED
);
    import proc_pkg::*;

    feeder_state_t    r_state;
    feeder_state_t    w_state_nxt;
    logic [AW-1:0]    r_pc;
    logic [AW-1:0]    w_pc_nxt;
    logic [7:0]       r_cnt;
    logic [7:0]       w_cnt_nxt;
    logic [7:0]       w_cnt_inc;
    logic             r_run_q;
    logic [WIDTH-1:0] w_word;
    logic             w_is_halt;
    logic             w_fetch;
    logic             w_we;
    logic             w_rise;
    logic             w_last;

    assign w_we = (r_state == FS_IDLE) && LOAD_EN;

    program_store #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_store (
        .i_clk   (CLKb),
        .i_we    (w_we),
        .i_waddr (LOAD_ADDR),
        .i_wdata (LOAD_DATA),
        .i_raddr (r_pc),
        .o_rdata (w_word)
    );

    assign w_is_halt = (w_word == HALT_WORD);
    assign w_fetch   = (r_state == FS_RUN) && EXT && !w_is_halt;
    assign w_rise    = RUN && !r_run_q;
    assign w_last    = (r_pc == AW'(DEPTH - 1));
    assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

    // Drive is purely combinational so the word lands at the same edge.
    assign BUS_DRIVE = w_fetch;
    assign BUS_OUT   = w_fetch ? w_word : '0;
    assign BUSY      = (r_state == FS_RUN);
    assign HALTED    = (r_state == FS_HALT);
    assign PC        = r_pc;
    assign INSTR_CNT = r_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            FS_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = FS_RUN;
                    w_pc_nxt    = '0;
                    w_cnt_nxt   = '0;
                end
            end
            FS_RUN: begin
                if (!RUN) begin
                    w_state_nxt = FS_IDLE;
                end else begin
                    if (EXT) begin
                        if (w_is_halt || w_last) begin
                            w_state_nxt = FS_HALT;
                        end else begin
                            w_pc_nxt = r_pc + 1'b1;
                        end
                    end
                    if (DONE) begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            FS_HALT: begin
                if (!RUN) begin
                    w_state_nxt = FS_IDLE;
                end else if (DONE) begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: w_state_nxt = FS_IDLE;
        endcase
    end

    always_ff @(posedge CLKb or negedge RESETn) begin
        if (!RESETn) begin
            r_state <= FS_IDLE;
            r_pc    <= '0;
            r_cnt   <= '0;
            r_run_q <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_run_q <= RUN;
        end
    end
endmodule
